// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   sa_state_t    : controller states (IDLE, RUN, DONE)
//   SA_MAX_WIDTH  : largest supported operand width

package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_t;

    localparam int SA_MAX_WIDTH = 32;

endpackage : serial_adder_pkg

// File: rtl/Full_Adder.sv
// Full_Adder
//   One-bit full adder, behavioural variant.
//   a, b : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out

module Full_Adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : Full_Adder

// File: rtl/serial_adder.sv
// serial_adder
//   Adds two WIDTH-bit operands one bit per clock through a single
//   Full_Adder, LSB first, with the carry held in a register between bits.
//
//   Handshake: start is only looked at in IDLE or DONE. The edge that sees
//   start=1 there captures a/b/cin and begins a WIDTH-cycle RUN. On the
//   last RUN edge sum/cout are written and done pulses high for exactly one
//   cycle. If start is high again during that DONE cycle the next operands
//   are accepted immediately (back-to-back, one result per WIDTH+1 cycles).
//
//   Ports
//     clk   : rising-edge clock
//     rst_n : synchronous active-low reset
//     start : request a new addition
//     a, b  : operands, captured on the accepting edge
//     cin   : carry-in, captured on the accepting edge
//     busy  : high while in RUN
//     done  : one-cycle pulse when sum/cout have just been updated
//     sum   : result, held until the next completion
//     cout  : final carry-out, held with sum

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    if (WIDTH < 1 || WIDTH > SA_MAX_WIDTH) begin : g_width_check
        $error("serial_adder: WIDTH must be in 1..%0d", SA_MAX_WIDTH);
    end

    localparam int              CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    sa_state_t        state;
    sa_state_t        state_next;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;

    Full_Adder u_fa (
        .a  (sh_a[0]),
        .b  (sh_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Each new sum bit enters at the MSB; after WIDTH shifts the first
    // (least significant) bit has walked down to bit 0. Written as shifts
    // rather than a concatenation so that WIDTH=1 needs no special case.
    assign psum_next = (psum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last_bit  = (cnt == LAST);

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: state_next = start ? RUN : IDLE;
            RUN:        state_next = last_bit ? DONE : RUN;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            sh_a  <= '0;
            sh_b  <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        psum  <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sh_a  <= sh_a >> 1;
                    sh_b  <= sh_b >> 1;
                    carry <= fa_co;
                    psum  <= psum_next;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) begin
                        sum  <= psum_next;
                        cout <= fa_co;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Directed scenarios on an 8-bit instance plus a randomized sweep on
//   1-, 8- and 32-bit instances. Inputs change and outputs are sampled
//   1 time unit after each rising edge.

module tb_serial_adder;
    import serial_adder_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- DUTs ----------------
    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start1, cin1, busy1, done1, cout1;
    logic [0:0]  a1, b1, sum1;
    logic        start32, cin32, busy32, done32, cout32;
    logic [31:0] a32, b32, sum32;

    serial_adder #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    serial_adder #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .cin(cin32),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    endtask

    task automatic drive_r(input int w, input logic st, input logic [31:0] va,
                           input logic [31:0] vb, input logic vc);
        case (w)
            1:       begin start1  = st; a1  = va[0:0]; b1  = vb[0:0]; cin1  = vc; end
            8:       begin start8  = st; a8  = va[7:0]; b8  = vb[7:0]; cin8  = vc; end
            default: begin start32 = st; a32 = va;      b32 = vb;      cin32 = vc; end
        endcase
    endtask

    task automatic sample_r(input int w, output logic d, output logic [31:0] s,
                            output logic c);
        case (w)
            1:       begin d = done1;  s = {31'b0, sum1}; c = cout1;  end
            8:       begin d = done8;  s = {24'b0, sum8}; c = cout8;  end
            default: begin d = done32; s = sum32;         c = cout32; end
        endcase
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        start8 = 'x; a8 = 'x; b8 = 'x; cin8 = 'x;
        start1 = 'x; a1 = 'x; b1 = 'x; cin1 = 'x;
        start32 = 'x; a32 = 'x; b32 = 'x; cin32 = 'x;
        step();
        step();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done8); end
        checks++; if (sum8 !== 8'h00) begin errors++; $display("FAIL reset_sum got=%h exp=00", sum8); end
        checks++; if (cout8 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout8); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
        checks++; if (sum32 !== 32'h0 || busy32 !== 1'b0) begin errors++; $display("FAIL reset_w32 got sum=%h busy=%b exp 0/0", sum32, busy32); end
        idle8();
        drive_r(1, 1'b0, 0, 0, 1'b0);
        drive_r(32, 1'b0, 0, 0, 1'b0);
        rst_n = 1'b1;
        step();
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL post_reset_idle got busy=%b done=%b exp 0/0", busy8, done8); end
    endtask

    // One addition on the 8-bit instance, checking busy length, the done
    // pulse and the result.
    task automatic run_vec(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                           input logic [7:0] es, input logic ec, input string name);
        int  nbusy;
        bit  seen;
        start8 = 1'b1; a8 = va; b8 = vb; cin8 = vc;
        step();
        idle8();
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1;
            else begin
                if (busy8) nbusy++;
                step();
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL %s_done_timeout got no done exp done within 20 cycles", name); end
        checks++; if (nbusy != 8) begin errors++; $display("FAIL %s_busy_len got=%0d exp=8", name, nbusy); end
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL %s_busy_at_done got=%b exp=0", name, busy8); end
        checks++; if (sum8 !== es) begin errors++; $display("FAIL %s_sum got=%h exp=%h", name, sum8, es); end
        checks++; if (cout8 !== ec) begin errors++; $display("FAIL %s_cout got=%b exp=%b", name, cout8, ec); end
        step();
        checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL %s_done_width got=%b exp=0", name, done8); end
    endtask

    task automatic test_basic();
        run_vec(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
    endtask

    task automatic test_carry();
        run_vec(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_ff_01");
        run_vec(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, "carry_ff_cin");
        run_vec(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "carry_cin_only");
    endtask

    // Previous result is 0x01/0 from test_carry; it must hold during RUN.
    task automatic test_start_ignored();
        bit seen;
        bit stable_ok;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        step();
        idle8();
        seen = 0;
        stable_ok = 1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) seen = 1;
            else begin
                if (sum8 !== 8'h01 || cout8 !== 1'b0) stable_ok = 0;
                if (i == 2) begin start8 = 1'b1; a8 = 8'h11; end
                else idle8();
                step();
            end
        end
        idle8();
        checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout got no done exp done"); end
        checks++; if (!stable_ok) begin errors++; $display("FAIL ignore_sum_stable got changed exp held 01/0"); end
        checks++; if (sum8 !== 8'h96 || cout8 !== 1'b0) begin errors++; $display("FAIL ignore_result got=%b/%h exp=0/96", cout8, sum8); end
        step();
        checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL ignore_no_requeue got busy=%b exp=0", busy8); end
    endtask

    task automatic test_reset_mid_run();
        bit spurious;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        step();
        idle8();
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL midrst_flags got busy=%b done=%b exp 0/0", busy8, done8); end
        checks++; if (sum8 !== 8'h00 || cout8 !== 1'b0) begin errors++; $display("FAIL midrst_result got=%b/%h exp=0/00", cout8, sum8); end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state, IDLE); end
        spurious = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 !== 1'b0 || busy8 !== 1'b0) spurious = 1;
            step();
        end
        checks++; if (spurious) begin errors++; $display("FAIL midrst_no_done got activity exp none"); end
    endtask

    task automatic test_back_to_back();
        int  t;
        int  t1;
        int  t2;
        bit  seen;
        t = 0; t1 = -1; t2 = -1;
        start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        step();
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) begin seen = 1; t1 = t; end
            else begin step(); t++; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_first_timeout got no done exp done"); end
        checks++; if (sum8 !== 8'h00 || cout8 !== 1'b1) begin errors++; $display("FAIL b2b_first got=%b/%h exp=1/00", cout8, sum8); end
        a8 = 8'h7F; b8 = 8'h01;
        step(); t++;
        checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got busy=%b exp=1", busy8); end
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (done8) begin seen = 1; t2 = t; end
            else begin step(); t++; end
        end
        checks++; if (!seen) begin errors++; $display("FAIL b2b_second_timeout got no done exp done"); end
        checks++; if (t2 - t1 != 9) begin errors++; $display("FAIL b2b_spacing got=%0d exp=9", t2 - t1); end
        checks++; if (sum8 !== 8'h80 || cout8 !== 1'b0) begin errors++; $display("FAIL b2b_second got=%b/%h exp=0/80", cout8, sum8); end
        idle8();
        step();
        checks++; if (busy8 !== 1'b0 || done8 !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b done=%b exp 0/0", busy8, done8); end
    endtask

    task automatic test_random(input int w, input int n);
        logic [31:0] mask;
        logic [31:0] ra, rb, gs, s;
        logic        rc, gc, d, c;
        logic [32:0] exp_full;
        int          ndone;
        int          bad_cnt, bad_val;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        bad_cnt = 0;
        bad_val = 0;
        for (int k = 0; k < n; k++) begin
            ra = $urandom() & mask;
            rb = $urandom() & mask;
            rc = 1'($urandom_range(0, 1));
            exp_full = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            drive_r(w, 1'b1, ra, rb, rc);
            step();
            drive_r(w, 1'b0, 0, 0, 1'b0);
            ndone = 0; gs = '0; gc = 1'b0;
            for (int i = 0; i < w + 2; i++) begin
                sample_r(w, d, s, c);
                if (d === 1'b1) begin ndone++; gs = s; gc = c; end
                step();
            end
            checks++;
            if (ndone != 1) begin
                errors++; bad_cnt++;
                $display("FAIL rand_w%0d_done_count got=%0d exp=1 (a=%h b=%h cin=%b)", w, ndone, ra, rb, rc);
            end
            checks++;
            if (gs !== (exp_full[31:0] & mask) || gc !== exp_full[w]) begin
                errors++; bad_val++;
                $display("FAIL rand_w%0d_result got=%b/%h exp=%b/%h (a=%h b=%h cin=%b)",
                         w, gc, gs, exp_full[w], exp_full[31:0] & mask, ra, rb, rc);
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        test_random(1, 1000);
        test_random(8, 1000);
        test_random(32, 1000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_adder
